led_status_ctrl: RTL



---
 rtl/led_status_ctrl.sv | 102 ++++++++++
 1 files changed

// File: rtl/led_status_ctrl.sv
// led_status_ctrl: multi-channel status LED driver with shared tick prescaler,
// power-up startup phase and per-channel OFF/ON/BLINK/ACTIVITY modes.
module led_status_ctrl #(
   parameter int CHANNELS      = 4,
   parameter int PRESCALE      = 2000,
   parameter int TICK_W        = 16,
   parameter int STARTUP_TICKS = 1024,
   parameter int BLINK_TICKS   = 250,
   parameter int FLASH_TICKS   = 50,
   parameter int SYNC_STAGES   = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [CHANNELS-1:0]   enable_i,
   input  logic [2*CHANNELS-1:0] mode_i,
   input  logic [CHANNELS-1:0]   event_i,
   output logic [CHANNELS-1:0]   led_o,
   output logic                  startup_o,
   output logic                  tick_o
);
   localparam int PW = $clog2(PRESCALE);
   typedef enum logic {STARTUP, RUN} state_t;
   state_t state, state_nxt;
   logic [PW-1:0] pcnt;
   logic [TICK_W-1:0] scnt, scnt_nxt;
   logic enter_run;
   always_ff @(posedge clk_i)
      if (rst_i) begin
         pcnt   <= '0;
         tick_o <= 1'b0;
      end else begin
         tick_o <= pcnt == PW'(PRESCALE - 1);
         pcnt   <= pcnt == PW'(PRESCALE - 1) ? '0 : pcnt + 1'b1;
      end
   always_ff @(posedge clk_i)
      if (rst_i) begin
         state <= STARTUP;
         scnt  <= '0;
      end else begin
         state <= state_nxt;
         scnt  <= scnt_nxt;
      end
   always_comb begin
      state_nxt = state;
      scnt_nxt  = scnt;
      enter_run = 1'b0;
      if (state == STARTUP && tick_o) begin
         if (scnt == TICK_W'(STARTUP_TICKS - 1)) begin
            state_nxt = RUN;
            enter_run = 1'b1;
         end else
            scnt_nxt = scnt + 1'b1;
      end
   end
   assign startup_o = state == STARTUP;
   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync;
      logic [1:0] md, mq;
      logic [TICK_W-1:0] cnt;
      logic prev, phase, flash, led_q, chg, fresh, rise, last_b, last_f, led_nxt;
      assign md      = mode_i[2*c +: 2];
      assign chg     = md != mq;
      assign fresh   = enter_run | (state == RUN && chg);
      assign rise    = sync[SYNC_STAGES-1] & ~prev & (md == 2'b11);
      assign last_b  = cnt == TICK_W'(BLINK_TICKS - 1);
      assign last_f  = cnt == TICK_W'(FLASH_TICKS - 1);
      // a channel whose mode just changed shows the new mode's fresh state
      assign led_nxt = (md == 2'b01) | ((md == 2'b10) & (chg | phase)) | ((md == 2'b11) & (chg | ~flash));
      assign led_o[c] = led_q;
      always_ff @(posedge clk_i)
         if (rst_i) begin
            sync  <= '0;
            prev  <= 1'b0;
            mq    <= 2'b00;
            cnt   <= '0;
            phase <= 1'b0;
            flash <= 1'b0;
            led_q <= 1'b0;
         end else begin
            sync  <= {sync[SYNC_STAGES-2:0], event_i[c]};
            prev  <= sync[SYNC_STAGES-1];
            mq    <= md;
            led_q <= state == STARTUP ? enable_i[c] : enable_i[c] & led_nxt;
            if (fresh) begin
               cnt   <= '0;
               phase <= 1'b1;
               flash <= 1'b0;
            end else if (state == RUN) begin
               if (rise) begin
                  flash <= 1'b1;
                  cnt   <= '0;
               end else if (tick_o && md == 2'b10) begin
                  cnt   <= last_b ? '0 : cnt + 1'b1;
                  phase <= phase ^ last_b;
               end else if (tick_o && md == 2'b11 && flash) begin
                  cnt   <= last_f ? '0 : cnt + 1'b1;
                  flash <= ~last_f;
               end
            end
         end
   end
endmodule
